// File: rtl/nibble_add_seq_pkg.sv
// ---------------------------------------------------------------------------
// nibble_add_seq_pkg
// Shared constants for the nibble-serial adder: slice width, default slice
// count and the controller state encoding.
// ---------------------------------------------------------------------------
package nibble_add_seq_pkg;

  // Width of the shared ripple-carry slice.
  localparam int NIBBLE_W        = 4;

  // Default number of slices per operand (operand width = 4 * NIBBLES).
  localparam int NIBBLES_DEFAULT = 4;

  // Controller state encoding, kept as plain constants for legacy tools.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

endpackage : nibble_add_seq_pkg

// File: rtl/nibble_add_seq_if.sv
// ---------------------------------------------------------------------------
// nibble_add_seq_if
// Request/result bundle of the nibble-serial adder.
//   i_start          : request an operation (taken only while o_ready = 1)
//   i_a, i_b         : operands, W = 4*NIBBLES bits
//   i_cin            : carry-in (ignored for subtraction)
//   i_sub            : 0 = A+B+Cin, 1 = A-B
//   o_ready          : block can accept i_start
//   o_done           : one-cycle pulse, result outputs updated
//   o_sum            : registered result
//   o_cout           : carry out of the MSB (0 = borrow when subtracting)
//   o_overflow       : signed overflow
// Modports: master drives requests, slave (the adder) drives results.
// ---------------------------------------------------------------------------
interface nibble_add_seq_if
  import nibble_add_seq_pkg::*;
#(
  parameter int NIBBLES = NIBBLES_DEFAULT
) ();

  localparam int W = NIBBLE_W * NIBBLES;

  logic         i_start;
  logic [W-1:0] i_a;
  logic [W-1:0] i_b;
  logic         i_cin;
  logic         i_sub;
  logic         o_ready;
  logic         o_done;
  logic [W-1:0] o_sum;
  logic         o_cout;
  logic         o_overflow;

  modport master (
    output i_start, i_a, i_b, i_cin, i_sub,
    input  o_ready, o_done, o_sum, o_cout, o_overflow
  );

  modport slave (
    input  i_start, i_a, i_b, i_cin, i_sub,
    output o_ready, o_done, o_sum, o_cout, o_overflow
  );

endinterface : nibble_add_seq_if

// File: rtl/nibble_add_seq_adder4.sv
// ---------------------------------------------------------------------------
// adder4
// 4-bit ripple-carry slice, purely combinational.
//   a, b  : slice operands
//   cin   : carry into bit 0
//   s     : slice sum
//   c3    : carry into bit 3 (used for signed overflow on the top slice)
//   cout  : carry out of bit 3
// ---------------------------------------------------------------------------
module adder4
  import nibble_add_seq_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] s,
  output logic                c3,
  output logic                cout
);

  // w_c[i] is the carry into bit i; w_c[NIBBLE_W] is the carry out.
  logic [NIBBLE_W:0] w_c;

  always_comb begin
    // NOTE: every variable written in always_comb gets a value up front,
    // so no path through the block can leave it unassigned and infer a latch.
    w_c    = '0;
    s      = '0;
    w_c[0] = cin;
    for (int i = 0; i < NIBBLE_W; i++) begin
      s[i]     = a[i] ^ b[i] ^ w_c[i];
      w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
    end
  end

  assign c3   = w_c[NIBBLE_W-1];
  assign cout = w_c[NIBBLE_W];

endmodule : adder4

// File: rtl/nibble_add_seq.sv
// ---------------------------------------------------------------------------
// nibble_add_seq
// Nibble-serial adder/subtractor. One 4-bit ripple slice is reused over
// NIBBLES cycles, least-significant nibble first; the full result, carry-out
// and signed overflow are published together when the last nibble finishes.
//   i_clk : clock, rising edge
//   i_rst : asynchronous, active-high reset
//   bus   : request/result bundle (slave side), see nibble_add_seq_if
// Timing: Start taken at edge t -> o_done high in the cycle after t+NIBBLES.
// ---------------------------------------------------------------------------
module nibble_add_seq
  import nibble_add_seq_pkg::*;
#(
  parameter int NIBBLES = NIBBLES_DEFAULT
) (
  input  logic             i_clk,
  input  logic             i_rst,
  nibble_add_seq_if.slave  bus
);

  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  // Controller state and datapath registers.
  state_t           r_state;
  logic [IDX_W-1:0] r_idx;
  logic             r_carry;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;      // already inverted for subtraction
  logic [W-1:0]     r_res;    // partial result, internal only
  logic [W-1:0]     r_sum;
  logic             r_cout;
  logic             r_ovf;

  // Slice connections.
  logic [NIBBLE_W-1:0] w_a_nib;
  logic [NIBBLE_W-1:0] w_b_nib;
  logic [NIBBLE_W-1:0] w_s_nib;
  logic                w_c3;
  logic                w_cout;
  logic [W-1:0]        w_res_next;
  logic                w_ready;
  logic                w_accept;
  logic                w_last;

  assign w_ready  = (r_state == ST_IDLE) || (r_state == ST_DONE);
  assign w_accept = w_ready && bus.i_start;
  assign w_last   = (r_idx == LAST_IDX);

  assign w_a_nib  = r_a[{r_idx, 2'b00} +: NIBBLE_W];
  assign w_b_nib  = r_b[{r_idx, 2'b00} +: NIBBLE_W];

  adder4 u_adder4 (
    .a    (w_a_nib),
    .b    (w_b_nib),
    .cin  (r_carry),
    .s    (w_s_nib),
    .c3   (w_c3),
    .cout (w_cout)
  );

  // Partial result with the current nibble merged in; on the last nibble
  // this is the complete sum, so it can be published in the same edge.
  always_comb begin
    w_res_next = r_res;
    w_res_next[{r_idx, 2'b00} +: NIBBLE_W] = w_s_nib;
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      // NOTE: the operand/result registers are plain flops, not a memory
      // array, so they are cleared with the rest of the state.
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_accept) begin
            r_state <= ST_RUN;
            r_idx   <= '0;
            r_a     <= bus.i_a;
            // Subtraction is A + ~B + 1: invert B here, inject the +1 as carry.
            r_b     <= bus.i_sub ? ~bus.i_b : bus.i_b;
            r_carry <= bus.i_sub ? 1'b1 : bus.i_cin;
          end else begin
            r_state <= ST_IDLE;
          end
        end

        ST_RUN: begin
          r_res   <= w_res_next;
          r_carry <= w_cout;
          if (w_last) begin
            // Publish everything on one edge so no partial result is visible.
            r_state <= ST_DONE;
            r_sum   <= w_res_next;
            r_cout  <= w_cout;
            r_ovf   <= w_c3 ^ w_cout;
          end else begin
            r_idx   <= r_idx + IDX_W'(1);
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_ready    = w_ready;
  assign bus.o_done     = (r_state == ST_DONE);
  assign bus.o_sum      = r_sum;
  assign bus.o_cout     = r_cout;
  assign bus.o_overflow = r_ovf;

endmodule : nibble_add_seq

// File: tb/tb_nibble_add_seq.sv
// ---------------------------------------------------------------------------
// tb_nibble_add_seq
// Directed vectors for nibble_add_seq (NIBBLES = 4, 16-bit operands).
// The driver pushes the hand-computed result and the cycle at which Done is
// due into a queue; a monitor pops and compares whenever Done is seen.
// ---------------------------------------------------------------------------
module tb_nibble_add_seq;

  localparam int NIB = 4;
  localparam int W   = 4 * NIB;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int unsigned  cyc;
  } exp_t;

  logic        clk;
  logic        rst;
  int unsigned cyc;
  int unsigned n_cmp;
  int unsigned n_fail;
  exp_t        sb_q[$];

  nibble_add_seq_if #(.NIBBLES(NIB)) bus ();

  nibble_add_seq #(.NIBBLES(NIB)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every Done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && bus.o_done) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sum",        32'(bus.o_sum),      32'(e.sum));
        check("cout",       32'(bus.o_cout),     32'(e.cout));
        check("overflow",   32'(bus.o_overflow), 32'(e.ovf));
        check("done_cycle", cyc,                 e.cyc);
        check("ready_in_done", 32'(bus.o_ready), 32'd1);
      end
    end
  end

  // Called at a negedge; presents one request and returns at the negedge
  // after the accepting edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic sub,
                       input logic [W-1:0] es, input logic ec, input logic eo);
    exp_t e;
    int   n;
    n = 0;
    while (!bus.o_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.o_ready) check("ready_timeout", 32'd0, 32'd1);
    bus.i_start = 1'b1;
    bus.i_a     = a;
    bus.i_b     = b;
    bus.i_cin   = cin;
    bus.i_sub   = sub;
    e.sum  = es;
    e.cout = ec;
    e.ovf  = eo;
    e.cyc  = cyc + 1 + NIB;
    sb_q.push_back(e);
    @(posedge clk);
    #1 bus.i_start = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus.o_done) seen = 1'b1;
    end
    if (!seen) check("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst         = 1'b1;
    bus.i_start = 1'b0;
    bus.i_a     = '0;
    bus.i_b     = '0;
    bus.i_cin   = 1'b0;
    bus.i_sub   = 1'b0;

    // Reset state.
    #3;
    check("rst_sum",   32'(bus.o_sum),      32'd0);
    check("rst_cout",  32'(bus.o_cout),     32'd0);
    check("rst_ovf",   32'(bus.o_overflow), 32'd0);
    check("rst_done",  32'(bus.o_done),     32'd0);
    check("rst_ready", 32'(bus.o_ready),    32'd1);

    // Release reset and request on the very first active edge.
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    issue(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
    wait_done();
    @(negedge clk);
    check("done_pulse_width", 32'(bus.o_done), 32'd0);
    check("hold_sum",         32'(bus.o_sum),  32'h5555);

    // Carry-out and signed overflow boundaries.
    issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    wait_done();
    issue(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    wait_done();
    issue(16'h0F0F, 16'h00F1, 1'b1, 1'b0, 16'h1001, 1'b0, 1'b0);
    wait_done();

    // Subtraction; Cin must be ignored.
    issue(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    wait_done();
    issue(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    wait_done();

    // Start and operand changes during RUN are ignored.
    issue(16'h00FF, 16'h0101, 1'b0, 1'b0, 16'h0200, 1'b0, 1'b0);
    bus.i_start = 1'b1;
    bus.i_a     = 16'hFFFF;
    bus.i_b     = 16'hFFFF;
    bus.i_sub   = 1'b1;
    @(negedge clk);
    check("busy_ready", 32'(bus.o_ready), 32'd0);
    check("no_partial_sum", 32'(bus.o_sum), 32'h7FFF);
    @(negedge clk);
    bus.i_start = 1'b0;
    wait_done();

    // Back-to-back: second Start presented during the Done cycle.
    issue(16'hA5A5, 16'h5A5A, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    wait_done();
    issue(16'h4000, 16'h4000, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    wait_done();

    // Reset between edges in the middle of an operation.
    issue(16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_sum",   32'(bus.o_sum),      32'd0);
    check("abort_cout",  32'(bus.o_cout),     32'd0);
    check("abort_ovf",   32'(bus.o_overflow), 32'd0);
    check("abort_ready", 32'(bus.o_ready),    32'd1);
    check("abort_done",  32'(bus.o_done),     32'd0);
    sb_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    issue(16'h0003, 16'h0004, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0);
    wait_done();

    repeat (4) @(negedge clk);
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule : tb_nibble_add_seq
